// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, round count, rcon seed and xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  localparam int         AES_NR        = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;

  // GF(2^8) multiply-by-x, reduced with the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Registered AES round-constant generator: clear wins over load, load wins over advance.
module aes_rcon_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic       clr_i,
  output logic [7:0] rcon_o
);
  import aes_pkg::*;

  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (clr_i)       rcon_d = 8'h00;
    else if (load_i) rcon_d = AES_RCON_INIT;
    else if (adv_i)  rcon_d = xtime(rcon_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcon_q <= 8'h00;
    else        rcon_q <= rcon_d;
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 iterative round sequencer: load, ten rounds, then hold the result until accepted.
// Optional AES_CTRL_PERF_EN builds a wrapping completed-block counter on blk_count.
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         dp_load,
  output logic         dp_round_en,
  output logic         dp_final,
  output logic [3:0]   round_idx,
  output logic [7:0]   rcon,
  input  logic [127:0] dp_state_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dataout,
  output logic         busy,
  output logic [31:0]  blk_count
);
  import aes_pkg::*;

  localparam logic [3:0] LAST   = 4'(AES_NR);
  localparam logic [3:0] PENULT = 4'(AES_NR - 1);

  aes_state_e state_q;
  logic [3:0] round_q;
  logic       round_en_q, final_q, out_valid_q;
  logic       in_hs, out_hs, last_rnd, bad_state;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ROUND) || (state_q == DONE);
  assign bad_state = !(in_ready || busy);
  assign in_hs     = in_valid && in_ready;
  // Gated by rst_n so a request held through reset never strobes the datapath
  assign dp_load   = in_hs && rst_n;
  assign out_hs    = out_valid_q && out_ready;
  assign last_rnd  = (state_q == ROUND) && (round_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      round_en_q  <= 1'b0;
      final_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_hs) begin
          state_q    <= ROUND;
          round_q    <= 4'd1;
          round_en_q <= 1'b1;
          final_q    <= 1'b0;
        end
        ROUND: if (round_q == LAST) begin
          state_q     <= DONE;
          round_q     <= 4'd0;
          round_en_q  <= 1'b0;
          final_q     <= 1'b0;
          out_valid_q <= 1'b1;
        end else begin
          round_q <= round_q + 4'd1;
          final_q <= (round_q == PENULT);
        end
        DONE: if (out_hs) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          round_q     <= 4'd0;
          round_en_q  <= 1'b0;
          final_q     <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  aes_rcon_gen u_rcon (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (in_hs),
    .adv_i  ((state_q == ROUND) && !last_rnd),
    .clr_i  (last_rnd || bad_state),
    .rcon_o (rcon)
  );

  assign dp_round_en = round_en_q;
  assign dp_final    = final_q;
  assign round_idx   = round_q;
  assign out_valid   = out_valid_q;
  assign dataout     = dp_state_i;

`ifdef AES_CTRL_PERF_EN
  logic [31:0] blk_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      blk_cnt_q <= 32'h0;
    else if (out_hs) blk_cnt_q <= blk_cnt_q + 32'd1;
  end
  assign blk_count = blk_cnt_q;
`else
  assign blk_count = 32'h0;
`endif

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative round sequencer for the AES-128 encryption datapath. It accepts a plaintext/key request over a valid/ready handshake and pulses the datapath's load strobe. It then steps the single-round datapath through rounds 1..10, supplying round index, round constant and final-round select each cycle. It presents the datapath state as the ciphertext under an output valid/ready handshake. The block sits between the request source (bus slave or test driver) and the round datapath; it holds no 128-bit state of its own.

## Interface
- NR, 10, number of rounds (fixed for AES-128; not overridable)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid; datain/key stable while high
- in_ready  out  1  controller idle, can accept a request
- dp_load  out  1  datapath loads state = datain ^ key and key register = key
- dp_round_en  out  1  datapath performs one round and one key-expansion step
- dp_final  out  1  current round is the final one (datapath skips MixColumns)
- round_idx  out  4  current round number, 0 when idle
- rcon  out  8  round constant for the current key-expansion step
- dp_state_i  in  128  datapath state register
- out_valid  out  1  dataout holds the ciphertext
- out_ready  in  1  consumer accepts dataout
- dataout  out  128  ciphertext, equal to dp_state_i
- busy  out  1  high in ROUND and DONE
- blk_count  out  32  completed-block counter (see Configuration)

## Operation
- States: IDLE, ROUND, DONE. Any unencoded state returns to IDLE on the next edge.
- IDLE:
  - in_ready = 1.
  - dp_load = in_valid && in_ready, combinational.
  - On a handshake edge: go to ROUND, round_idx = 1, rcon = 8'h01.
- ROUND:
  - dp_round_en = 1.
  - dp_final = (round_idx == 10).
  - Each edge: round_idx increments and rcon advances by xtime (8'h80 -> 8'h1b).
  - Sequence for rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
  - On the edge where round_idx == 10: go to DONE, round_idx = 0, rcon = 8'h00.
- DONE:
  - out_valid = 1, dataout = dp_state_i.
  - Waits indefinitely for out_ready. On out_valid && out_ready: go to IDLE.
- in_valid is ignored outside IDLE; in_ready stays low.
- dataout is driven from dp_state_i in every state. Consumers qualify it with out_valid.
- Reset values: state IDLE, round_idx 0, rcon 8'h00, dp_round_en 0, dp_final 0, out_valid 0, busy 0, blk_count 0, in_ready 1.
- Reset asserted mid-operation aborts immediately to IDLE. Datapath contents are don't-care, and no output handshake is generated for the aborted block.

## Timing
- Handshake edge T0. Rounds 1..10 are performed on edges T1..T10.
- out_valid rises in the cycle after T10: 11 cycles from the request cycle to the first valid cycle.
- Minimum throughput is one block per 12 cycles. in_ready returns in the cycle after the output handshake; there is no overlap of output and input handshakes.
- The round counter never exceeds 10. The rcon register is 8 bits, and the xtime reduction uses 8'h1b.
- All outputs except dp_load, in_ready, busy and dataout are registered.

## Configuration
- AES_CTRL_PERF_EN:
  - Defined: blk_count increments by 1 on every output handshake and wraps 32'hffffffff -> 0.
  - Undefined: blk_count is tied to 32'h0 and no counter flops are built.
  - The port exists in both builds.

## Structure
- Shared package aes_pkg holds:
  - the state enum (IDLE, ROUND, DONE);
  - AES_NR = 10;
  - AES_RCON_INIT = 8'h01;
  - the xtime function, shared with the MixColumns logic in the datapath.
- One natural sub-module, aes_rcon_gen: registered round-constant generator with load/advance/clear inputs.

## Test plan
- After reset release: in_ready = 1, out_valid = 0, round_idx = 0, rcon = 00. Reset with in_valid high produces no dp_load until rst_n = 1.
- Known-answer test with the real round datapath attached:
  - key 5468617473206d79204b756e67204675, datain 54776f204f6e65204e696e652054776f -> dataout 29c3505f571420f6402299b31a02d73a.
  - out_valid first high exactly 11 cycles after the request cycle.
- Round sequence: log rcon and round_idx over ROUND cycles -> 01..36 as listed and indices 1..10. dp_final is high only at index 10.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles -> out_valid and dataout stable, in_ready = 0, and a second in_valid is ignored.
  - Release -> IDLE next cycle.
- Reset mid-operation: assert rst_n = 0 at round 5 -> all outputs return to their reset values asynchronously. A new request afterwards completes correctly with the FIPS-197 vector (key 000102030405060708090a0b0c0d0e0f, datain 00112233445566778899aabbccddeeff -> dataout 69c4e0d86a7b0430d8cdb78070b4c55a).
- Block counter: run 3 back-to-back blocks -> blk_count = 3 with AES_CTRL_PERF_EN defined, 0 without.
